// File: rtl/stopwatch_ctrl.sv
// Stopwatch control sequencer: button debounce, IDLE/RUN/PAUSE/DONE FSM and centisecond tick prescaler.
// Define STOPWATCH_LAP_EN to enable the lap button and display-freeze control.

module stopwatch_debounce #(
  parameter int unsigned DB_CYCLES = 1000000
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic evt_c
);
  localparam int unsigned CW = $clog2(DB_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES);

  logic          sync1;
  logic          sync2;
  logic          level;
  logic          level_d;
  logic [CW-1:0] cnt;

  // Level follows the synced input only after it has differed for DB_CYCLES+1 straight samples
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      level   <= 1'b0;
      level_d <= 1'b0;
      cnt     <= '0;
    end else begin
      sync1   <= raw;
      sync2   <= sync1;
      level_d <= level;
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        level <= sync2;
        cnt   <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

  assign evt_c = level & ~level_d;
endmodule

module stopwatch_ctrl #(
  parameter int unsigned DIV_SLOW  = 1000000,
  parameter int unsigned DIV_FAST  = 2,
  parameter int unsigned DB_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       clr,
  input  logic       lap,
  input  logic       quick,
  input  logic       at_max,
  output logic       tick,
  output logic       clear,
  output logic       go,
  output logic       freeze,
  output logic [1:0] state
);
  localparam int unsigned DIV_MAX = (DIV_SLOW > DIV_FAST) ? DIV_SLOW : DIV_FAST;
  localparam int unsigned PS_W    = $clog2(DIV_MAX + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t          st_q;
  state_t          st_n;
  logic [PS_W-1:0] psc_q;
  logic [PS_W-1:0] psc_n;
  logic [PS_W-1:0] div_last;
  logic            terminal;
  logic            tick_n;
  logic            clear_n;
  logic            start_evt;
  logic            clr_evt;

  stopwatch_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_start (
    .clk   (clk),
    .reset (reset),
    .raw   (start),
    .evt_c (start_evt)
  );

  stopwatch_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_clr (
    .clk   (clk),
    .reset (reset),
    .raw   (clr),
    .evt_c (clr_evt)
  );

`ifdef STOPWATCH_LAP_EN
  logic lap_evt;
  logic frz_q;
  logic frz_n;

  stopwatch_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_lap (
    .clk   (clk),
    .reset (reset),
    .raw   (lap),
    .evt_c (lap_evt)
  );

  assign freeze = frz_q;
`else
  logic lap_unused;
  assign lap_unused = lap;
  assign freeze     = 1'b0;
`endif

  // Rate is re-evaluated every cycle so a quick change takes effect mid-period
  assign div_last = quick ? PS_W'(DIV_FAST - 1) : PS_W'(DIV_SLOW - 1);
  assign terminal = (psc_q >= div_last);

  // Next-state, prescaler and pulse decode
  always_comb begin
    st_n    = st_q;
    psc_n   = psc_q;
    tick_n  = 1'b0;
    clear_n = 1'b0;
`ifdef STOPWATCH_LAP_EN
    frz_n   = frz_q;
`endif
    case (st_q)
      ST_IDLE: begin
        psc_n = '0;
        if (clr_evt) begin
          clear_n = 1'b1;
`ifdef STOPWATCH_LAP_EN
          frz_n   = 1'b0;
`endif
        end else if (start_evt) begin
          st_n = ST_RUN;
        end
      end
      ST_RUN: begin
        if (terminal) begin
          psc_n = '0;
          if (at_max) begin
            st_n = ST_DONE;
          end else begin
            tick_n = 1'b1;
            if (start_evt) st_n = ST_PAUSE;
          end
        end else begin
          psc_n = psc_q + PS_W'(1);
          if (start_evt) st_n = ST_PAUSE;
        end
`ifdef STOPWATCH_LAP_EN
        if (terminal && at_max) frz_n = 1'b0;
        else if (lap_evt)       frz_n = ~frz_q;
`endif
      end
      ST_PAUSE: begin
`ifdef STOPWATCH_LAP_EN
        if (lap_evt && frz_q) frz_n = 1'b0;
`endif
        if (clr_evt) begin
          st_n    = ST_IDLE;
          psc_n   = '0;
          clear_n = 1'b1;
`ifdef STOPWATCH_LAP_EN
          frz_n   = 1'b0;
`endif
        end else if (start_evt) begin
          st_n = ST_RUN;
        end
      end
      default: begin
        psc_n = '0;
        if (clr_evt) begin
          st_n    = ST_IDLE;
          clear_n = 1'b1;
`ifdef STOPWATCH_LAP_EN
          frz_n   = 1'b0;
`endif
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      st_q  <= ST_IDLE;
      psc_q <= '0;
      tick  <= 1'b0;
      clear <= 1'b0;
      go    <= 1'b0;
`ifdef STOPWATCH_LAP_EN
      frz_q <= 1'b0;
`endif
    end else begin
      st_q  <= st_n;
      psc_q <= psc_n;
      tick  <= tick_n;
      clear <= clear_n;
      go    <= (st_n == ST_RUN);
`ifdef STOPWATCH_LAP_EN
      frz_q <= frz_n;
`endif
    end
  end

  assign state = st_q;
endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Scoreboard bench for stopwatch_ctrl: expected tick/clear cycles are queued as stimulus is planned
// and checked against the DUT pulses; state/go/freeze are checked at fixed points.

module tb_stopwatch_ctrl;
  localparam int unsigned DB = 4;
  localparam int unsigned DS = 10;
  localparam int unsigned DF = 2;
`ifdef STOPWATCH_LAP_EN
  localparam logic LAP_ON = 1'b1;
`else
  localparam logic LAP_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       clr;
  logic       lap;
  logic       quick;
  logic       at_max;
  logic       tick;
  logic       clear;
  logic       go;
  logic       freeze;
  logic [1:0] state;

  int cyc     = 0;
  int n_check = 0;
  int n_pass  = 0;
  int exp_tick_q[$];
  int exp_clr_q[$];

  stopwatch_ctrl #(.DIV_SLOW(DS), .DIV_FAST(DF), .DB_CYCLES(DB)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .clr    (clr),
    .lap    (lap),
    .quick  (quick),
    .at_max (at_max),
    .tick   (tick),
    .clear  (clear),
    .go     (go),
    .freeze (freeze),
    .state  (state)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_check++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
  endtask

  task automatic wait_until(input int e);
    while (cyc < e) @(negedge clk);
  endtask

  task automatic set_btn(input int sel, input logic v);
    case (sel)
      0:       start = v;
      1:       clr   = v;
      default: lap   = v;
    endcase
  endtask

  task automatic press(input int sel, input int hold);
    set_btn(sel, 1'b1);
    repeat (hold) @(negedge clk);
    set_btn(sel, 1'b0);
  endtask

  // Pulse scoreboard: every tick/clear must land exactly on a queued cycle
  always @(negedge clk) begin
    if (exp_tick_q.size() != 0 && exp_tick_q[0] == cyc) begin
      check("tick_at", 32'(tick), 1);
      void'(exp_tick_q.pop_front());
    end else if (tick === 1'b1) begin
      check("tick_unexpected", 32'(tick), 0);
    end
    if (exp_clr_q.size() != 0 && exp_clr_q[0] == cyc) begin
      check("clear_at", 32'(clear), 1);
      void'(exp_clr_q.pop_front());
    end else if (clear === 1'b1) begin
      check("clear_unexpected", 32'(clear), 0);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish (cycle %0d)", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int k;
    int r;
    int p;
    int q;
    int c;
    int s;
    reset = 1'b1; start = 1'b0; clr = 1'b0; lap = 1'b0; quick = 1'b0; at_max = 1'b0;
    @(negedge clk);
    repeat (3) @(negedge clk);
    check("rst_state", 32'(state), 0);
    check("rst_go", 32'(go), 0);
    check("rst_tick", 32'(tick), 0);
    check("rst_clear", 32'(clear), 0);
    check("rst_freeze", 32'(freeze), 0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Bounce: too short to be accepted
    press(0, 3);
    repeat (15) @(negedge clk);
    check("bounce_state", 32'(state), 0);
    check("bounce_go", 32'(go), 0);

    // Clean press -> RUN at k+8, ticks every DS, then quick/slow rate changes
    k = cyc;
    r = k + 8;
    exp_tick_q.push_back(r + 10);
    exp_tick_q.push_back(r + 20);
    exp_tick_q.push_back(r + 28);
    exp_tick_q.push_back(r + 30);
    exp_tick_q.push_back(r + 32);
    exp_tick_q.push_back(r + 34);
    exp_tick_q.push_back(r + 44);
    exp_tick_q.push_back(r + 54);
    start = 1'b1;
    wait_until(k + 7);
    check("pre_run_state", 32'(state), 0);
    wait_until(r);
    check("run_state", 32'(state), 1);
    check("run_go", 32'(go), 1);
    start = 1'b0;
    wait_until(r + 27);
    quick = 1'b1;
    wait_until(r + 34);
    quick = 1'b0;

    // Pause with prescaler at 6, hold 50 cycles, resume
    wait_until(r + 52);
    press(0, 8);
    p = r + 60;
    check("pause_state", 32'(state), 2);
    check("pause_go", 32'(go), 0);
    wait_until(p + 50);
    press(0, 8);
    q = p + 58;
    check("resume_state", 32'(state), 1);
    exp_tick_q.push_back(q + 4);
    exp_tick_q.push_back(q + 14);

    // at_max at terminal -> DONE with suppressed tick
    wait_until(q + 14);
    at_max = 1'b1;
    wait_until(q + 24);
    check("done_state", 32'(state), 3);
    check("done_go", 32'(go), 0);
    check("done_tick_supp", 32'(tick), 0);
    press(0, 8);
    wait_until(q + 34);
    check("done_start_ign", 32'(state), 3);
    c = cyc;
    exp_clr_q.push_back(c + 8);
    press(1, 8);
    check("done_clr_state", 32'(state), 0);
    at_max = 1'b0;
    wait_until(c + 20);
    c = cyc;
    exp_clr_q.push_back(c + 8);
    press(1, 8);
    check("idle_clr_state", 32'(state), 0);

    // Lap toggles freeze in RUN while ticks continue
    repeat (4) @(negedge clk);
    k = cyc;
    s = k + 8;
    exp_tick_q.push_back(s + 10);
    exp_tick_q.push_back(s + 20);
    exp_tick_q.push_back(s + 30);
    press(0, 8);
    check("lap_run_state", 32'(state), 1);
    wait_until(s + 2);
    press(2, 8);
    check("lap_freeze_on", 32'(freeze), 32'(LAP_ON));
    wait_until(s + 20);
    check("lap_freeze_hold", 32'(freeze), 32'(LAP_ON));
    press(2, 8);
    check("lap_freeze_off", 32'(freeze), 0);

    // Reset mid-RUN returns outputs to reset values, no clear pulse
    wait_until(s + 31);
    reset = 1'b1;
    wait_until(s + 32);
    check("mid_rst_state", 32'(state), 0);
    check("mid_rst_go", 32'(go), 0);
    check("mid_rst_tick", 32'(tick), 0);
    check("mid_rst_clear", 32'(clear), 0);
    check("mid_rst_freeze", 32'(freeze), 0);
    reset = 1'b0;
    repeat (12) @(negedge clk);
    check("post_rst_state", 32'(state), 0);
    check("tick_q_left", 32'(exp_tick_q.size()), 0);
    check("clr_q_left", 32'(exp_clr_q.size()), 0);

    $display("%0d/%0d checks passed", n_pass, n_check);
    $finish;
  end
endmodule
